// File: rtl/alu_issuer_pkg.sv
// alu_issuer_pkg: shared widths, op/select encodings, FSM states and op-to-select mapping
package alu_issuer_pkg;
  localparam int WIDTH = 32;
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_SBB = 4'd3,
                         OP_INC = 4'd4, OP_DEC = 4'd5, OP_MOV = 4'd6, OP_AND = 4'd7,
                         OP_OR = 4'd8, OP_XOR = 4'd9, OP_NOT = 4'd10, OP_LSL = 4'd11,
                         OP_LSR = 4'd12, OP_ASL = 4'd13, OP_ASR = 4'd14, OP_LDI = 4'd15;
  localparam logic [4:0] SEL_ADD = 5'b00000, SEL_ADC = 5'b00100, SEL_SUB = 5'b00010,
                         SEL_SBB = 5'b00110, SEL_INC = 5'b00001, SEL_DEC = 5'b00101,
                         SEL_MOV = 5'b00011, SEL_AND = 5'b10000, SEL_OR = 5'b10010,
                         SEL_XOR = 5'b10001, SEL_NOT = 5'b10011, SEL_LSL = 5'b01000,
                         SEL_LSR = 5'b01010, SEL_ASL = 5'b01001, SEL_ASR = 5'b01011,
                         SEL_ZERO = 5'b11111;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
  function automatic logic [4:0] op_to_sel(input logic [3:0] op);
    case (op)
      OP_ADD: return SEL_ADD;
      OP_ADC: return SEL_ADC;
      OP_SUB: return SEL_SUB;
      OP_SBB: return SEL_SBB;
      OP_INC: return SEL_INC;
      OP_DEC: return SEL_DEC;
      OP_MOV: return SEL_MOV;
      OP_AND: return SEL_AND;
      OP_OR: return SEL_OR;
      OP_XOR: return SEL_XOR;
      OP_NOT: return SEL_NOT;
      OP_LSL: return SEL_LSL;
      OP_LSR: return SEL_LSR;
      OP_ASL: return SEL_ASL;
      OP_ASR: return SEL_ASR;
      default: return SEL_ZERO;
    endcase
  endfunction
endpackage

// File: rtl/alu_issuer_regfile.sv
// alu_issuer_regfile: NREGS x WIDTH register file, two async reads, one sync write, sync clear
module alu_issuer_regfile #(
  parameter int WIDTH = 32,
  parameter int NREGS = 8,
  localparam int RAW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [RAW-1:0]   wa,
  input  logic [WIDTH-1:0] wd,
  input  logic [RAW-1:0]   ra1,
  input  logic [RAW-1:0]   ra2,
  output logic [WIDTH-1:0] rd1,
  output logic [WIDTH-1:0] rd2
);
  logic [WIDTH-1:0] mem [NREGS];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    else if (we && int'(wa) < NREGS) mem[wa] <= wd;
  assign rd1 = int'(ra1) < NREGS ? mem[ra1] : '0;
  assign rd2 = int'(ra2) < NREGS ? mem[ra2] : '0;
endmodule

// File: rtl/alu_op_issuer.sv
// alu_op_issuer: issues register-file micro-ops to an external ALU and returns results over a handshake
module alu_op_issuer
  import alu_issuer_pkg::*;
#(
  parameter int WIDTH = alu_issuer_pkg::WIDTH,
  parameter int NREGS = 8,
  localparam int RAW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [RAW-1:0]   cmd_rd,
  input  logic [RAW-1:0]   cmd_rs1,
  input  logic [RAW-1:0]   cmd_rs2,
  input  logic             cmd_use_imm,
  input  logic [WIDTH-1:0] cmd_imm,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [4:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_f
);
  state_t state, next;
  logic [RAW-1:0] rd_q;
  logic [3:0] op_q;
  logic [WIDTH-1:0] imm_q, rf_a, rf_b, res;
  logic accept;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign accept = cmd_valid && cmd_ready;
  assign res = op_q == OP_LDI ? imm_q : alu_f;
  alu_issuer_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_rf (
    .clk(clk), .rst(rst), .we(state == CAPTURE), .wa(rd_q), .wd(res),
    .ra1(cmd_rs1), .ra2(cmd_rs2), .rd1(rf_a), .rd2(rf_b)
  );
  always_comb begin
    next = state;
    next = state == IDLE ? (cmd_valid ? ISSUE : IDLE) :
           state == ISSUE ? CAPTURE :
           state == CAPTURE ? RESP :
           (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= SEL_ZERO;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      rd_q <= '0;
      op_q <= OP_ADD;
      imm_q <= '0;
    end else begin
      state <= next;
      if (accept) begin
        alu_a <= rf_a;
        alu_b <= cmd_use_imm ? cmd_imm : rf_b;
        alu_sel <= op_to_sel(cmd_op);
        rd_q <= cmd_rd;
        op_q <= cmd_op;
        imm_q <= cmd_imm;
      end
      if (state == CAPTURE) begin
        rsp_data <= res;
        rsp_zero <= res == '0;
      end
    end
endmodule

// File: tb/tb_alu_op_issuer.sv
// tb_alu_op_issuer: scoreboard bench with an environment ALU and a register-level reference model
module tb_alu_op_issuer;
  localparam int W = 32, N = 8, RA = 3;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_use_imm = 0, rsp_ready = 0;
  logic cmd_ready, rsp_valid, rsp_zero;
  logic [3:0] cmd_op = 0;
  logic [RA-1:0] cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0;
  logic [W-1:0] cmd_imm = 0, rsp_data, alu_a, alu_b, alu_f;
  logic [4:0] alu_sel;
  int n_cmp = 0, n_bad = 0, rr_mode = 0;
  logic [W-1:0] rf_m [N];
  logic [W:0] sb [$];
  logic [W:0] e_mon;
  logic [W-1:0] r;
  localparam logic [4:0] SELS [16] = '{5'b00000, 5'b00100, 5'b00010, 5'b00110, 5'b00001,
    5'b00101, 5'b00011, 5'b10000, 5'b10010, 5'b10001, 5'b10011, 5'b01000, 5'b01010,
    5'b01001, 5'b01011, 5'b11111};
  always #5 clk = ~clk;
  alu_op_issuer #(.WIDTH(W), .NREGS(N)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_imm(cmd_use_imm),
    .cmd_imm(cmd_imm), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_f(alu_f)
  );
  always_comb begin
    alu_f = '0;
    case (alu_sel)
      5'b00000: alu_f = alu_a + alu_b;
      5'b00100: alu_f = alu_a + alu_b + 1;
      5'b00010: alu_f = alu_a - alu_b;
      5'b00110: alu_f = alu_a - alu_b - 1;
      5'b00001: alu_f = alu_a + 1;
      5'b00101: alu_f = alu_a - 1;
      5'b00011: alu_f = alu_a;
      5'b10000: alu_f = alu_a & alu_b;
      5'b10010: alu_f = alu_a | alu_b;
      5'b10001: alu_f = alu_a ^ alu_b;
      5'b10011: alu_f = ~alu_a;
      5'b01000: alu_f = alu_a << 2;
      5'b01010: alu_f = alu_a >> 2;
      5'b01001: alu_f = alu_a <<< 2;
      5'b01011: alu_f = W'($signed(alu_a) >>> 2);
      default: alu_f = '0;
    endcase
  end
  function automatic logic [W-1:0] ref_res(input int op, input logic [W-1:0] a, b, imm);
    case (op)
      0: return a + b;
      1: return a + b + 1;
      2: return a - b;
      3: return a - b - 1;
      4: return a + 1;
      5: return a - 1;
      6: return a;
      7: return a & b;
      8: return a | b;
      9: return a ^ b;
      10: return ~a;
      11, 13: return a * 4;
      12: return a / 4;
      14: return {a[W-1], a[W-1], a[W-1:2]};
      default: return imm;
    endcase
  endfunction
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_alu_a"}, alu_a, 0);
    chk({tag, "_alu_b"}, alu_b, 0);
    chk({tag, "_alu_sel"}, W'(alu_sel), W'(5'b11111));
    chk({tag, "_rsp_valid"}, W'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_zero"}, W'(rsp_zero), 0);
  endtask
  task automatic send(input int op, input int rd, input int rs1, input int rs2, input bit ui,
                      input logic [W-1:0] imm, input bit abort, output logic [W-1:0] res);
    logic [W-1:0] a, b;
    int t;
    res = '0;
    @(negedge clk);
    cmd_op = 4'(op); cmd_rd = RA'(rd); cmd_rs1 = RA'(rs1); cmd_rs2 = RA'(rs2);
    cmd_use_imm = ui; cmd_imm = imm; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: cmd_ready=%b, expected 1 within 50 cycles", cmd_ready);
      cmd_valid = 0;
      return;
    end
    a = rf_m[rs1];
    b = ui ? imm : rf_m[rs2];
    res = ref_res(op, a, b, imm);
    @(posedge clk);
    #1 cmd_valid = 0;
    chk("issue_alu_a", alu_a, a);
    chk("issue_alu_b", alu_b, b);
    chk("issue_alu_sel", W'(alu_sel), W'(SELS[op]));
    chk("busy_cmd_ready", W'(cmd_ready), 0);
    if (abort) begin
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < N; i++) rf_m[i] = '0;
      return;
    end
    sb.push_back({res == '0, res});
    rf_m[rd] = res;
    @(posedge clk);
    #1 chk("e1_rsp_valid", W'(rsp_valid), 0);
    @(posedge clk);
    #1 chk("e2_rsp_valid", W'(rsp_valid), 1);
  endtask
  task automatic drain;
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2 rsp_ready = rr_mode == 0 ? 1'b1 : rr_mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
  end
  initial forever begin
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL rsp_unexpected: got response %h, expected none", rsp_data);
      end else begin
        e_mon = sb.pop_front();
        chk("rsp_data", rsp_data, e_mon[W-1:0]);
        chk("rsp_zero", W'(rsp_zero), W'(e_mon[W]));
      end
    end
  end
  initial begin
    for (int i = 0; i < N; i++) rf_m[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    rst = 0;
    @(negedge clk);
    chk("post_rst_cmd_ready", W'(cmd_ready), 1);
    send(15, 1, 0, 0, 1, 5, 0, r);
    send(15, 2, 0, 0, 1, 3, 0, r);
    send(0, 3, 1, 2, 0, 0, 0, r);
    send(2, 4, 2, 2, 0, 0, 0, r);
    send(3, 5, 2, 1, 0, 0, 0, r);
    send(1, 6, 1, 2, 0, 0, 0, r);
    send(7, 6, 1, 0, 1, 4, 0, r);
    send(10, 7, 1, 0, 0, 0, 0, r);
    send(11, 7, 1, 0, 0, 0, 0, r);
    drain();
    rr_mode = 1;
    send(0, 3, 1, 2, 0, 0, 0, r);
    @(negedge clk);
    cmd_op = 15; cmd_rd = 7; cmd_use_imm = 1; cmd_imm = 32'hDEAD; cmd_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_rsp_valid", W'(rsp_valid), 1);
      chk("bp_rsp_data", rsp_data, r);
      chk("bp_rsp_zero", W'(rsp_zero), W'(r == '0));
      chk("bp_cmd_ready", W'(cmd_ready), 0);
    end
    cmd_valid = 0;
    rr_mode = 0;
    send(4, 1, 1, 0, 0, 0, 0, r);
    send(6, 2, 1, 0, 0, 0, 0, r);
    drain();
    send(0, 3, 1, 2, 0, 0, 1, r);
    chk_reset_outputs("abort");
    chk("abort_cmd_ready", W'(cmd_ready), 1);
    repeat (4) @(posedge clk);
    send(6, 0, 3, 0, 0, 0, 0, r);
    drain();
    rr_mode = 2;
    for (int k = 0; k < 150; k++) begin
      send($urandom_range(0, 15), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
           $urandom_range(0, N - 1), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0 ? W'(0) : W'($urandom), 0, r);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
